cpu_stall: RTL and testbench

CPU_STALL -- requirements
Module: cpu_stall

---
 rtl/cpu_stall.sv | 143 ++++++++++++++
 tb/tb_cpu_stall.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stall.sv
// Hack CPU core with a memory-ready stall handshake and a RUN/HALT state machine.
// Optional commit/stall performance counters are enabled with `define CPU_PERF_CNT_EN.
module cpu_stall #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic              instrValid,
  input  logic [DATA_W-1:0] inM,
  input  logic              memReady,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc,
`ifdef CPU_PERF_CNT_EN
  output logic [31:0]       instretCnt,
  output logic [31:0]       stallCnt,
`endif
  output logic              stalled,
  output logic              halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;

  logic                is_c, a_bit;
  logic                zx, nx, zy, ny, f, no;
  logic                dest_a, dest_d, dest_m;
  logic [2:0]          jump;
  logic [DATA_W-1:0]   alu_x, alu_y, alu_out;
  logic                zr, ng;
  logic                needs_m, stall, commit, take, halt_now;

  always_comb begin
    is_c   = instruction[15];
    a_bit  = instruction[12];
    zx     = instruction[11];
    nx     = instruction[10];
    zy     = instruction[9];
    ny     = instruction[8];
    f      = instruction[7];
    no     = instruction[6];
    dest_a = instruction[5];
    dest_d = instruction[4];
    dest_m = instruction[3];
    jump   = instruction[2:0];
  end

  always_comb begin
    alu_x = d_q;
    if (zx) alu_x = '0;
    if (nx) alu_x = ~alu_x;
    alu_y = a_bit ? inM : a_q;
    if (zy) alu_y = '0;
    if (ny) alu_y = ~alu_y;
    alu_out = f ? (alu_x + alu_y) : (alu_x & alu_y);
    if (no) alu_out = ~alu_out;
    zr = (alu_out == '0);
    ng = alu_out[DATA_W-1];
  end

  always_comb begin
    needs_m  = is_c & (a_bit | dest_m);
    stall    = instrValid & needs_m & ~memReady;
    commit   = instrValid & ~stall & ~halted;
    take     = is_c & ((jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr));
    halt_now = commit & is_c & (jump == 3'b111) & (a_q[ADDR_W-1:0] == pc_q);
  end

  // A, D and pc all sample pre-edge values, so a jump with dest A targets the old A.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    if (commit) begin
      if (!is_c) begin
        a_d = {{(DATA_W-15){1'b0}}, instruction[14:0]};
      end else begin
        if (dest_a) a_d = alu_out;
        if (dest_d) d_d = alu_out;
      end
      if (halt_now) begin
        state_d = HALT;
      end else if (take) begin
        pc_d = a_q[ADDR_W-1:0];
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
    end
  end

  assign halted   = (state_q == HALT);
  assign stalled  = stall & ~halted;
  assign outM     = alu_out;
  assign writeM   = is_c & dest_m & instrValid & ~halted & ~reset;
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;

`ifdef CPU_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    instret_d   = instret_q + (commit ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + (stalled ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      instret_q   <= instret_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instretCnt = instret_q;
  assign stallCnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_stall.sv
// Directed bench for cpu_stall: a 16-bit and a 32-bit core run the same program,
// with hand-computed expectations for registers, pc, stall handshake and halt.
module tb_cpu_stall;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        instrValid;
  logic        memReady;
  logic [15:0] in_m16;
  logic [31:0] in_m32;

  logic [15:0] out_m16;
  logic        write_m16, stalled16, halted16;
  logic [14:0] addr16, pc16;
  logic [31:0] out_m32;
  logic        write_m32, stalled32, halted32;
  logic [14:0] addr32, pc32;
`ifdef CPU_PERF_CNT_EN
  logic [31:0] instret16, stallcnt16, instret32, stallcnt32;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int wr_base;

  always #5 clk = ~clk;

  cpu_stall #(.DATA_W(16), .ADDR_W(15)) u16 (
    .clk(clk), .reset(reset), .instruction(instruction), .instrValid(instrValid),
    .inM(in_m16), .memReady(memReady), .outM(out_m16), .writeM(write_m16),
    .addressM(addr16), .pc(pc16),
`ifdef CPU_PERF_CNT_EN
    .instretCnt(instret16), .stallCnt(stallcnt16),
`endif
    .stalled(stalled16), .halted(halted16)
  );

  cpu_stall #(.DATA_W(32), .ADDR_W(15)) u32 (
    .clk(clk), .reset(reset), .instruction(instruction), .instrValid(instrValid),
    .inM(in_m32), .memReady(memReady), .outM(out_m32), .writeM(write_m32),
    .addressM(addr32), .pc(pc32),
`ifdef CPU_PERF_CNT_EN
    .instretCnt(instret32), .stallCnt(stallcnt32),
`endif
    .stalled(stalled32), .halted(halted32)
  );

  always @(posedge clk)
    if (!reset && write_m16 && memReady) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic exec(input logic [15:0] ins, input logic vld, input logic rdy);
    instruction = ins;
    instrValid  = vld;
    memReady    = rdy;
    @(posedge clk);
    #1;
  endtask

  // Present an instruction without committing it, to observe the ALU combinationally.
  task automatic peek(input logic [15:0] ins);
    instruction = ins;
    instrValid  = 1'b0;
    memReady    = 1'b1;
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 16'hE308;
    instrValid  = 1'b1;
    memReady    = 1'b0;
    in_m16      = '0;
    in_m32      = '0;
    #1;
    check("rst_writeM", 32'(write_m16), 32'd0);
    check("rst_pc", 32'(pc16), 32'd0);
    check("rst_halted", 32'(halted16), 32'd0);
    @(posedge clk); #1;
    check("rst_addr", 32'(addr16), 32'd0);
    peek(16'hE300);
    check("rst_D", 32'(out_m16), 32'd0);
`ifdef CPU_PERF_CNT_EN
    check("rst_stallcnt", stallcnt16, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // A=5, D=A
    exec(16'h0005, 1'b1, 1'b1);
    check("ainst_pc", 32'(pc16), 32'd1);
    check("ainst_A", 32'(addr16), 32'd5);
    exec(16'hEC10, 1'b1, 1'b1);
    check("dA_pc", 32'(pc16), 32'd2);
    peek(16'hE300);
    check("dA_D", 32'(out_m16), 32'd5);

    // M=D at A=7 stalled three cycles
    exec(16'h0007, 1'b1, 1'b1);
    wr_base     = wr_cnt;
    instruction = 16'hE308;
    instrValid  = 1'b1;
    memReady    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_stalled", 32'(stalled16), 32'd1);
      check("stall_writeM", 32'(write_m16), 32'd1);
      check("stall_outM", 32'(out_m16), 32'd5);
      @(posedge clk); #1;
      check("stall_pc_hold", 32'(pc16), 32'd3);
    end
    memReady = 1'b1;
    #1;
    check("ready_stalled", 32'(stalled16), 32'd0);
    check("ready_writeM", 32'(write_m16), 32'd1);
    check("ready_addr", 32'(addr16), 32'd7);
    @(posedge clk); #1;
    check("write_pc", 32'(pc16), 32'd4);
    check("write_once", 32'(wr_cnt - wr_base), 32'd1);
`ifdef CPU_PERF_CNT_EN
    check("perf_stallcnt", stallcnt16, 32'd3);
    check("perf_instret", instret16, 32'd4);
`endif

    // D=M reads inM
    in_m16 = 16'h1234;
    in_m32 = 32'h0000_1234;
    exec(16'hFC10, 1'b1, 1'b1);
    check("dM_pc", 32'(pc16), 32'd5);
    peek(16'hE300);
    check("dM_D", 32'(out_m16), 32'h1234);

    // D;JEQ taken with D=0, not taken with D=1
    exec(16'hEA90, 1'b1, 1'b1);
    exec(16'h0010, 1'b1, 1'b1);
    exec(16'hE302, 1'b1, 1'b1);
    check("jeq_taken_pc", 32'(pc16), 32'h10);
    exec(16'hEFD0, 1'b1, 1'b1);
    exec(16'h0010, 1'b1, 1'b1);
    exec(16'hE302, 1'b1, 1'b1);
    check("jeq_fall_pc", 32'(pc16), 32'h13);

    // A=0;JMP jumps to the old A
    exec(16'h0020, 1'b1, 1'b1);
    exec(16'hEAA7, 1'b1, 1'b1);
    check("destA_jmp_pc", 32'(pc16), 32'h20);
    check("destA_jmp_A", 32'(addr16), 32'd0);
    exec(16'h0005, 1'b0, 1'b1);
    check("invalid_pc_hold", 32'(pc16), 32'h20);
    check("invalid_A_hold", 32'(addr16), 32'd0);

    // pc wraps from 0x7FFF
    exec(16'h7FFF, 1'b1, 1'b1);
    exec(16'hEA87, 1'b1, 1'b1);
    check("jmp_7fff", 32'(pc16), 32'h7FFF);
    exec(16'h0000, 1'b1, 1'b1);
    check("pc_wrap", 32'(pc16), 32'd0);

    // D=-1 at 32 bits, then A=0x7FFF zero-extended
    exec(16'hEE90, 1'b1, 1'b1);
    peek(16'hE300);
    check("d32_minus1", out_m32, 32'hFFFF_FFFF);
    check("d32_ng", 32'(out_m32[31]), 32'd1);
    check("d16_minus1", 32'(out_m16), 32'h0000_FFFF);
    exec(16'h7FFF, 1'b1, 1'b1);
    peek(16'hEC00);
    check("a32_zext", out_m32, 32'h0000_7FFF);
    check("pc32_track", 32'(pc32), 32'd2);

    // Halt: 0;JMP at pc=5 with A=5
    exec(16'h0000, 1'b1, 1'b1);
    exec(16'h0000, 1'b1, 1'b1);
    check("pre_halt_pc", 32'(pc16), 32'd4);
    exec(16'h0005, 1'b1, 1'b1);
    check("halt_target_pc", 32'(pc16), 32'd5);
    check("not_halted_yet", 32'(halted16), 32'd0);
    exec(16'hEA87, 1'b1, 1'b1);
    check("halted", 32'(halted16), 32'd1);
    check("halt_pc", 32'(pc16), 32'd5);
    instruction = 16'hE308;
    instrValid  = 1'b1;
    memReady    = 1'b0;
    #1;
    check("halt_writeM", 32'(write_m16), 32'd0);
    check("halt_stalled", 32'(stalled16), 32'd0);
    exec(16'h0001, 1'b1, 1'b1);
    check("halt_ignore_pc", 32'(pc16), 32'd5);
    check("halt_ignore_A", 32'(addr16), 32'd5);

    // Reset clears halt; reset mid-stall abandons the write
    #2 reset = 1'b1;
    #1;
    check("unhalt", 32'(halted16), 32'd0);
    check("unhalt_pc", 32'(pc16), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exec(16'h0009, 1'b1, 1'b1);
    check("first_commit_pc", 32'(pc16), 32'd1);
    check("first_commit_A", 32'(addr16), 32'd9);
    exec(16'hE308, 1'b1, 1'b0);
    check("midstall_writeM", 32'(write_m16), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midstall_rst_writeM", 32'(write_m16), 32'd0);
    check("midstall_rst_pc", 32'(pc16), 32'd0);
    check("midstall_rst_A", 32'(addr16), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
